// File: rtl/hilo_pkg.sv
// hilo_pkg: shared constants, accumulate op encodings and op decode helpers for the HI/LO file.
package hilo_pkg;
  localparam int MaxDataW = 64;
  localparam logic [MaxDataW-1:0] ZeroWord = '0;
  typedef enum logic [1:0] {
    ACC_MADD  = 2'b00,
    ACC_MADDU = 2'b01,
    ACC_MSUB  = 2'b10,
    ACC_MSUBU = 2'b11
  } acc_op_e;
  function automatic logic is_signed(input acc_op_e op);
    return !op[0];
  endfunction
  function automatic logic is_sub(input acc_op_e op);
    return op[1];
  endfunction
endpackage

// File: rtl/hilo_mac_pipe.sv
// hilo_mac_pipe: two-stage multiply-accumulate with valid/ready handshake and flush.
module hilo_mac_pipe
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                acc_valid,
  output logic                acc_ready,
  input  logic [1:0]          acc_op,
  input  logic [DATA_W-1:0]   acc_a,
  input  logic [DATA_W-1:0]   acc_b,
  input  logic                flush,
  input  logic [2*DATA_W-1:0] hilo,
  output logic                acc_busy,
  output logic                commit_valid,
  output logic [2*DATA_W-1:0] commit_value
);
  logic                s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, accept;
  acc_op_e             op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*DATA_W-1:0] prod_q, prod_d, ext_a, ext_b;
  always_comb begin
    acc_busy     = !reset && (s1_valid_q || s2_valid_q);
    acc_ready    = !reset && !(s1_valid_q || s2_valid_q);
    accept       = acc_valid && acc_ready && !flush;
    s1_valid_d   = !reset && !flush && accept;
    s2_valid_d   = !reset && !flush && s1_valid_q;
    op_d         = accept ? acc_op_e'(acc_op) : op_q;
    a_d          = accept ? acc_a : a_q;
    b_d          = accept ? acc_b : b_q;
    ext_a        = is_signed(op_q) ? {{DATA_W{a_q[DATA_W-1]}}, a_q} : {{DATA_W{1'b0}}, a_q};
    ext_b        = is_signed(op_q) ? {{DATA_W{b_q[DATA_W-1]}}, b_q} : {{DATA_W{1'b0}}, b_q};
    prod_d       = s1_valid_q ? ext_a * ext_b : prod_q;
    commit_valid = s2_valid_q && !flush && !reset;
    commit_value = is_sub(op_q) ? hilo - prod_q : hilo + prod_q;
  end
  always_ff @(posedge clk) begin
    s1_valid_q <= s1_valid_d;
    s2_valid_q <= s2_valid_d;
    op_q       <= op_d;
    a_q        <= a_d;
    b_q        <= b_d;
    prod_q     <= prod_d;
  end
endmodule

// File: rtl/hilo_acc_regfile.sv
// hilo_acc_regfile: multi-port HI/LO register pair with forwarded reads and a pipelined accumulate.
module hilo_acc_regfile
  import hilo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_WP = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WP-1:0]        we_hi,
  input  logic [NUM_WP-1:0]        we_lo,
  input  logic [NUM_WP*DATA_W-1:0] wdata_hi,
  input  logic [NUM_WP*DATA_W-1:0] wdata_lo,
  input  logic                     acc_valid,
  output logic                     acc_ready,
  input  logic [1:0]               acc_op,
  input  logic [DATA_W-1:0]        acc_a,
  input  logic [DATA_W-1:0]        acc_b,
  input  logic                     flush,
  output logic                     acc_busy,
  output logic [DATA_W-1:0]        o_hi,
  output logic [DATA_W-1:0]        o_lo
);
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, wr_hi, wr_lo;
  logic                wr_hi_en, wr_lo_en, commit_valid;
  logic [2*DATA_W-1:0] commit_value;
  hilo_mac_pipe #(.DATA_W(DATA_W)) u_mac (
    .clk          (clk),
    .reset        (reset),
    .acc_valid    (acc_valid),
    .acc_ready    (acc_ready),
    .acc_op       (acc_op),
    .acc_a        (acc_a),
    .acc_b        (acc_b),
    .flush        (flush),
    .hilo         ({hi_q, lo_q}),
    .acc_busy     (acc_busy),
    .commit_valid (commit_valid),
    .commit_value (commit_value)
  );
  // Later ports overwrite earlier ones so the youngest writer wins.
  always_comb begin
    wr_hi_en = 1'b0;
    wr_lo_en = 1'b0;
    wr_hi    = ZeroWord[DATA_W-1:0];
    wr_lo    = ZeroWord[DATA_W-1:0];
    for (int p = 0; p < NUM_WP; p++) begin
      if (we_hi[p]) begin
        wr_hi_en = 1'b1;
        wr_hi    = wdata_hi[p*DATA_W +: DATA_W];
      end
      if (we_lo[p]) begin
        wr_lo_en = 1'b1;
        wr_lo    = wdata_lo[p*DATA_W +: DATA_W];
      end
    end
    hi_d = reset ? ZeroWord[DATA_W-1:0] : wr_hi_en ? wr_hi
         : commit_valid ? commit_value[2*DATA_W-1:DATA_W] : hi_q;
    lo_d = reset ? ZeroWord[DATA_W-1:0] : wr_lo_en ? wr_lo
         : commit_valid ? commit_value[DATA_W-1:0] : lo_q;
    o_hi = hi_d;
    o_lo = lo_d;
  end
  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
  end
endmodule

// File: tb/tb_hilo_acc_regfile.sv
// tb_hilo_acc_regfile: directed and randomized checks of the HI/LO file against an arithmetic model.
module tb_hilo_acc_regfile;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  we_hi = '0, we_lo = '0;
  logic [63:0] wdata_hi = '0, wdata_lo = '0;
  logic        acc_valid = 1'b0, flush = 1'b0;
  logic [1:0]  acc_op = '0;
  logic [31:0] acc_a = '0, acc_b = '0;
  logic        acc_ready, acc_busy;
  logic [31:0] o_hi, o_lo;
  logic [31:0] mhi, mlo;
  int tests = 0;
  int fails = 0;

  hilo_acc_regfile #(.DATA_W(32), .NUM_WP(2)) dut (
    .clk(clk), .reset(reset), .we_hi(we_hi), .we_lo(we_lo),
    .wdata_hi(wdata_hi), .wdata_lo(wdata_lo), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
    .flush(flush), .acc_busy(acc_busy), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full-precision product of the operands, added to or subtracted from {hi,lo} mod 2^64.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, b,
                                        input logic [63:0] hl);
    longint sa, sb;
    logic [63:0] p;
    sa = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
    p = 64'(sa * sb);
    return op[1] ? hl - p : hl + p;
  endfunction

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    we_hi = 2'b01; we_lo = 2'b01;
    wdata_hi = {32'h0, h}; wdata_lo = {32'h0, l};
    tick();
    we_hi = '0; we_lo = '0;
    mhi = h; mlo = l;
  endtask

  task automatic do_acc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    exp = model(op, a, b, {mhi, mlo});
    acc_op = op; acc_a = a; acc_b = b; acc_valid = 1'b1;
    #1 check("ready_idle", 32'(acc_ready), 32'd1);
    tick();
    acc_valid = 1'b0;
    #1 check("ready_s1", 32'(acc_ready), 32'd0);
    check("busy_s1", 32'(acc_busy), 32'd1);
    tick();
    #1 check("ready_s2", 32'(acc_ready), 32'd0);
    check("fwd_hi_s2", o_hi, exp[63:32]);
    check("fwd_lo_s2", o_lo, exp[31:0]);
    tick();
    #1 check("ready_done", 32'(acc_ready), 32'd1);
    check("hi_commit", o_hi, exp[63:32]);
    check("lo_commit", o_lo, exp[31:0]);
    {mhi, mlo} = exp;
  endtask

  initial begin
    logic [1:0]  rw_hi, rw_lo;
    logic [31:0] d[4];
    logic [31:0] eh, el;
    mhi = '0; mlo = '0;
    tick();
    #1 check("rst_o_hi", o_hi, 32'h0);
    check("rst_o_lo", o_lo, 32'h0);
    check("rst_ready", 32'(acc_ready), 32'd0);
    check("rst_busy", 32'(acc_busy), 32'd0);
    reset = 1'b0;
    // Reset while an accumulate sits in stage 1 must drop it.
    set_hilo(32'h1234, 32'h0);
    acc_op = 2'b00; acc_a = 32'd1; acc_b = 32'd1; acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0; reset = 1'b1;
    #1 check("rst_mid_busy", 32'(acc_busy), 32'd0);
    tick();
    reset = 1'b0;
    #1 check("after_rst_hi", o_hi, 32'h0);
    check("after_rst_lo", o_lo, 32'h0);
    check("after_rst_busy", 32'(acc_busy), 32'd0);
    tick(); tick();
    check("no_commit_hi", o_hi, 32'h0);
    check("no_commit_lo", o_lo, 32'h0);
    mhi = '0; mlo = '0;
    // Youngest port wins per half.
    we_hi = 2'b11; we_lo = 2'b01;
    wdata_hi = {32'h22, 32'h11}; wdata_lo = {32'h99, 32'h33};
    #1 check("prio_fwd_hi", o_hi, 32'h22);
    check("prio_fwd_lo", o_lo, 32'h33);
    tick();
    we_hi = '0; we_lo = '0;
    #1 check("prio_reg_hi", o_hi, 32'h22);
    check("prio_reg_lo", o_lo, 32'h33);
    mhi = 32'h22; mlo = 32'h33;
    set_hilo(32'h0, 32'h0);
    do_acc(2'b00, 32'hFFFFFFFE, 32'd3);
    check("madd_hi", o_hi, 32'hFFFFFFFF);
    check("madd_lo", o_lo, 32'hFFFFFFFA);
    set_hilo(32'h0, 32'h0);
    do_acc(2'b01, 32'hFFFFFFFE, 32'd3);
    check("maddu_hi", o_hi, 32'h00000002);
    check("maddu_lo", o_lo, 32'hFFFFFFFA);
    set_hilo(32'h0, 32'h0);
    do_acc(2'b11, 32'd1, 32'd1);
    check("msubu_hi", o_hi, 32'hFFFFFFFF);
    check("msubu_lo", o_lo, 32'hFFFFFFFF);
    do_acc(2'b10, 32'd1, 32'hFFFFFFFF);
    check("msub_hi", o_hi, 32'h0);
    check("msub_lo", o_lo, 32'h0);
    // Flush during stage 2.
    acc_op = 2'b00; acc_a = 32'd2; acc_b = 32'd2; acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    tick();
    flush = 1'b1;
    #1 check("flush_s2_fwd_lo", o_lo, 32'h0);
    tick();
    flush = 1'b0;
    #1 check("flush_s2_hi", o_hi, 32'h0);
    check("flush_s2_lo", o_lo, 32'h0);
    check("flush_s2_ready", 32'(acc_ready), 32'd1);
    // Flush during stage 1.
    acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 check("flush_s1_ready", 32'(acc_ready), 32'd1);
    check("flush_s1_busy", 32'(acc_busy), 32'd0);
    tick(); tick();
    check("flush_s1_lo", o_lo, 32'h0);
    // Flush beats a simultaneous accept.
    acc_valid = 1'b1; flush = 1'b1;
    tick();
    acc_valid = 1'b0; flush = 1'b0;
    #1 check("flush_accept_busy", 32'(acc_busy), 32'd0);
    // Direct HI write collides with the stage-2 commit.
    acc_op = 2'b00; acc_a = 32'd1; acc_b = 32'd5; acc_valid = 1'b1;
    tick();
    acc_valid = 1'b0;
    tick();
    we_hi = 2'b01; wdata_hi = {32'h0, 32'hAA};
    #1 check("coll_fwd_hi", o_hi, 32'hAA);
    check("coll_fwd_lo", o_lo, 32'h5);
    tick();
    we_hi = '0;
    #1 check("coll_hi", o_hi, 32'hAA);
    check("coll_lo", o_lo, 32'h5);
    mhi = 32'hAA; mlo = 32'h5;
    // Randomized direct writes against a youngest-wins model.
    for (int i = 0; i < 20; i++) begin
      rw_hi = 2'($urandom); rw_lo = 2'($urandom);
      foreach (d[k]) d[k] = $urandom;
      we_hi = rw_hi; we_lo = rw_lo;
      wdata_hi = {d[1], d[0]}; wdata_lo = {d[3], d[2]};
      eh = rw_hi[1] ? d[1] : rw_hi[0] ? d[0] : mhi;
      el = rw_lo[1] ? d[3] : rw_lo[0] ? d[2] : mlo;
      tick();
      we_hi = '0; we_lo = '0;
      #1 check("rnd_wr_hi", o_hi, eh);
      check("rnd_wr_lo", o_lo, el);
      mhi = eh; mlo = el;
    end
    // Randomized accumulates chained on the evolving model state.
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 0) set_hilo($urandom, $urandom);
      do_acc(2'($urandom), $urandom, $urandom);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
